// File: rtl/key4_reader.sv
// rtl/key4_reader.sv - debounced reader for four active-low push-buttons
// Produces clean level/press/release per key and a 4-bit user value with hold.
module key4_reader #(
  parameter int TICK_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] nKey,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] code,
  output logic       hold
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [3:0]    sync1;
  logic [3:0]    s;
  logic [PW-1:0] pre;
  logic          tick;
  logic [CW-1:0] cnt [4];

  // Inverted at the pad so everything downstream is 1 = pressed.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= ~nKey;
      s     <= sync1;
    end
  end

  assign tick = (pre == '0);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pre <= PRE_LOAD;
    end else if (tick) begin
      pre <= PRE_LOAD;
    end else begin
      pre <= pre - PW'(1);
    end
  end

  // Any cycle agreeing with the stable level restarts that key's count.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < 4; i++) begin
        if (s[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            key_state[i]   <= s[i];
            key_press[i]   <= s[i];
            key_release[i] <= ~s[i];
            cnt[i]         <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  // Clear wins over inc/dec; inc and dec together cancel.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      code <= '0;
      hold <= 1'b0;
    end else begin
      if (key_press[2]) begin
        code <= '0;
      end else if (!hold) begin
        if (key_press[0] && !key_press[1]) begin
          code <= code + 4'd1;
        end else if (key_press[1] && !key_press[0]) begin
          code <= code - 4'd1;
        end
      end
      if (key_press[3]) begin
        hold <= ~hold;
      end
    end
  end

endmodule
